simple_fetch: RTL and testbench
===============================

Name: simple_fetch

Overview:
- Instruction fetch unit for the SIMPLE 16-bit core: owns the PC, reads instruction words from instruction memory, and presents them to the decode/controller stage over a valid/ready handshake.
- It is the producing end of the `instr` interface the controller consumes. It pre-detects HLT so it stops fetching once HLT issues.
- It accepts branch redirects from execute (taken PCSrc plus target).
- Memory is word-addressed; one outstanding request at a time.

Parameters:
- PC_WIDTH, 16, width of PC and imem_addr.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- exec  in  1  pulse: start from IDLE / resume from HALTED.
- imem_req  out  1  one-cycle read request.
- imem_addr  out  PC_WIDTH  word address; valid when imem_req=1.
- imem_rvalid  in  1  read data valid; at least 1 cycle after imem_req.
- imem_rdata  in  16  instruction word.
- instr  out  16  instruction to decode.
- instr_pc  out  PC_WIDTH  address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts.
- redirect_valid  in  1  taken branch.
- redirect_pc  in  PC_WIDTH  branch target.
- halted  out  1  high while in HALTED.

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - instr=NOP (16'hC0E0), instr_pc=0, instr_valid=0, halted=0, drop=0.
  - Reset mid-request: any later imem_rvalid is ignored while in IDLE.
- FSM states: IDLE, ISSUE, WAIT, HOLD, HALTED. All outputs are registered or Moore; imem_req=1 only in ISSUE, with imem_addr=pc.
- IDLE: exec=1 -> ISSUE. Everything else is ignored, including redirect.
- ISSUE: always -> WAIT next cycle. If redirect_valid, set drop=1 and pc<=redirect_pc.
- WAIT:
  - imem_rvalid=1 with drop=0 and no redirect: instr<=imem_rdata, instr_pc<=pc, pc<=pc+1 (mod 2^PC_WIDTH, 16'hFFFF wraps to 0), instr_valid<=1 -> HOLD.
  - imem_rvalid=1 with drop=1: discard the data, drop<=0 -> ISSUE (fetches the redirected pc).
  - redirect_valid=1 without rvalid: drop<=1, pc<=redirect_pc, stay in WAIT.
  - redirect_valid and rvalid in the same cycle: discard the data, pc<=redirect_pc, drop<=0 -> ISSUE.
- HOLD:
  - instr and instr_pc stay stable while instr_valid=1 and instr_ready=0.
  - Handshake (instr_ready=1) with instr==HLT (op1=2'b11, instr[7:4]=4'b1111): instr_valid<=0 -> HALTED.
  - Handshake with any other instruction: instr_valid<=0 -> ISSUE.
  - redirect_valid has priority over the handshake: instr_valid<=0, pc<=redirect_pc -> ISSUE.
- HALTED: halted=1, no requests, redirect ignored. exec=1 -> ISSUE at the current pc (HLT address + 1), halted<=0.
- Latency and throughput:
  - ISSUE at cycle t; earliest rvalid at t+1; earliest instr_valid at t+2.
  - Best case one instruction per 3 cycles.
- imem_rvalid outside WAIT is ignored.

Optional Feature:
- Macro: SIMPLE_FETCH_STATS_EN.
- Defined: adds outputs fetch_count[31:0] and stall_count[31:0].
  - fetch_count increments on each instr handshake.
  - stall_count increments each cycle with instr_valid=1 and instr_ready=0.
  - Both clear on reset and saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package simple_pkg:
  - OP1_* / OP2_* / OP3_* encoding constants (LD=2'b00, BR group op1=2'b10 op2=3'b100/3'b111, HLT op3=4'b1111, NOP op3=4'b1110).
  - INSTR_NOP=16'hC0E0, INSTR_HLT=16'hC0F0.
  - fetch_state_t enum.
- No sub-module is required; the optional counters may be a small simple_sat_counter.

Test Plan:
- Reset, then exec pulse; memory returns 16'h8801 at addr 0 with 1-cycle latency and instr_ready=1 -> imem_req at cycle 1 addr 0; instr_valid at cycle 3 with instr=16'h8801, instr_pc=0; next request to addr 1.
- Hold instr_ready=0 for 5 cycles -> instr and instr_pc stable, no imem_req. Ready=1 -> exactly one handshake, then next request.
- Redirect to 16'h0040 while in WAIT; stale rvalid returns 16'h1234 -> 16'h1234 never appears on instr; next imem_addr=16'h0040.
- Fetch 16'hC0F0 at addr 5 -> after handshake halted=1 and no imem_req for 10 cycles. exec pulse -> request at addr 6.
- RESET_PC=16'hFFFF -> first instr_pc=16'hFFFF, next imem_addr=16'h0000.
- Assert reset during WAIT, then rvalid arrives -> instr_valid stays 0, state IDLE, pc=RESET_PC.

Source files
------------

// File: rtl/simple_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : simple_pkg                                                 |
// | Purpose : Shared encodings for the SIMPLE 16-bit core: opcode field  |
// |           constants, canonical NOP/HLT words, fetch FSM state type   |
// |           and the HLT pre-decode helper.                             |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package simple_pkg;

  // Major opcode, instr[15:14]
  localparam logic [1:0] OP1_LD  = 2'b00;
  localparam logic [1:0] OP1_BR  = 2'b10;
  localparam logic [1:0] OP1_SYS = 2'b11;

  // Branch group sub-opcode, instr[13:11]
  localparam logic [2:0] OP2_B   = 3'b100;
  localparam logic [2:0] OP2_BC  = 3'b111;

  // System group function, instr[7:4]
  localparam logic [3:0] OP3_HLT = 4'b1111;
  localparam logic [3:0] OP3_NOP = 4'b1110;

  localparam logic [15:0] INSTR_NOP = 16'hC0E0;
  localparam logic [15:0] INSTR_HLT = 16'hC0F0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_t;

  // HLT is recognised from op1 and op3 alone; the remaining bits are don't-care.
  function automatic logic is_hlt(input logic [15:0] word);
    return (word[15:14] == OP1_SYS) && (word[7:4] == OP3_HLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/simple_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : simple_fetch_if                                            |
// | Purpose : Bundles the instruction-memory read bus and the instr      |
// |           valid/ready stream between fetch and its neighbours.       |
// | Ports   : master = fetch unit (drives imem_req/addr, instr*)         |
// |           slave  = memory + decode side (drives rvalid/rdata, ready) |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface simple_fetch_if #(
  parameter int PC_WIDTH = 16
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_rvalid;
  logic [15:0]         imem_rdata;
  logic [15:0]         instr;
  logic [PC_WIDTH-1:0] instr_pc;
  logic                instr_valid;
  logic                instr_ready;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_rvalid, imem_rdata, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/simple_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : simple_fetch                                               |
// | Purpose : Instruction fetch unit. Owns the PC, issues one word read  |
// |           at a time, presents the word to decode over valid/ready,   |
// |           follows branch redirects and parks itself after HLT.       |
// | Ports   : clock, reset (sync, active-high), exec (start/resume),     |
// |           bus (simple_fetch_if.master), redirect_valid/redirect_pc,  |
// |           halted; fetch_count/stall_count when the optional macro    |
// |           SIMPLE_FETCH_STATS_EN is defined.                          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module simple_fetch
  import simple_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                exec,
  simple_fetch_if.master      bus,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                halted
`ifdef SIMPLE_FETCH_STATS_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [31:0]         stall_count
`endif
);

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc;
  logic                drop;       // in-flight read belongs to a squashed path
  logic [15:0]         instr_q;
  logic [PC_WIDTH-1:0] instr_pc_q;
  logic                instr_valid_q;

  // Moore outputs: the request lives exactly in ISSUE and always carries pc.
  assign bus.imem_req    = (state == ST_ISSUE);
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign halted          = (state == ST_HALTED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      drop          <= 1'b0;
      instr_q       <= INSTR_NOP;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (exec) state <= ST_ISSUE;
        end

        ST_ISSUE: begin
          state <= ST_WAIT;
          if (redirect_valid) begin
            drop <= 1'b1;
            pc   <= redirect_pc;
          end
        end

        ST_WAIT: begin
          if (bus.imem_rvalid && redirect_valid) begin
            // Data belongs to the old path; refetch from the target at once.
            pc    <= redirect_pc;
            drop  <= 1'b0;
            state <= ST_ISSUE;
          end else if (bus.imem_rvalid && drop) begin
            drop  <= 1'b0;
            state <= ST_ISSUE;
          end else if (bus.imem_rvalid) begin
            instr_q       <= bus.imem_rdata;
            instr_pc_q    <= pc;
            pc            <= pc + 1'b1;
            instr_valid_q <= 1'b1;
            state         <= ST_HOLD;
          end else if (redirect_valid) begin
            drop <= 1'b1;
            pc   <= redirect_pc;
          end
        end

        ST_HOLD: begin
          // A redirect squashes the held word even if decode is ready.
          if (redirect_valid) begin
            instr_valid_q <= 1'b0;
            pc            <= redirect_pc;
            state         <= ST_ISSUE;
          end else if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            state         <= is_hlt(instr_q) ? ST_HALTED : ST_ISSUE;
          end
        end

        ST_HALTED: begin
          if (exec) state <= ST_ISSUE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SIMPLE_FETCH_STATS_EN
  // A squashing redirect wins over ready, so it does not count as a handshake.
  logic handshake;
  logic stall;
  assign handshake = instr_valid_q && bus.instr_ready && !redirect_valid;
  assign stall     = instr_valid_q && !bus.instr_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (handshake && (fetch_count != '1)) fetch_count <= fetch_count + 32'd1;
      if (stall && (stall_count != '1))     stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_simple_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_simple_fetch                                            |
// | Purpose : Self-checking bench for simple_fetch: directed cycle       |
// |           table, HLT/resume, reset mid-request, RESET_PC wrap, and   |
// |           a randomized run against an instruction-stream model.      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_simple_fetch;
  import simple_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        exec = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        halted;

  logic        exec2 = 1'b0;
  logic        redirect_valid2 = 1'b0;
  logic [15:0] redirect_pc2 = 16'h0;
  logic        halted2;

  always #5 clock = ~clock;

  simple_fetch_if #(.PC_WIDTH(16)) bus ();
  simple_fetch_if #(.PC_WIDTH(16)) bus2 ();

`ifdef SIMPLE_FETCH_STATS_EN
  logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;
`endif

  simple_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .exec(exec), .bus(bus),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
`ifdef SIMPLE_FETCH_STATS_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  simple_fetch #(.PC_WIDTH(16), .RESET_PC(16'hFFFF)) dut2 (
    .clock(clock), .reset(reset), .exec(exec2), .bus(bus2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .halted(halted2)
`ifdef SIMPLE_FETCH_STATS_EN
    , .fetch_count(fetch_count2), .stall_count(stall_count2)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [15:0] mem [256];
  logic        auto_mem = 1'b0;
  int          fixed_lat = 0;
  logic        auto_rvalid = 1'b0;
  logic [15:0] auto_rdata = 16'h0;
  logic        man_rvalid = 1'b0;
  logic [15:0] man_rdata = 16'h0;

  assign bus.imem_rvalid = auto_mem ? auto_rvalid : man_rvalid;
  assign bus.imem_rdata  = auto_mem ? auto_rdata  : man_rdata;

  initial begin
    bit          pend;
    int          cnt;
    logic [15:0] paddr;
    pend = 0; cnt = 0; paddr = 0;
    forever begin
      @(negedge clock);
      auto_rvalid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          auto_rvalid = 1'b1;
          auto_rdata  = mem[paddr[7:0]];
          pend        = 0;
        end
      end
      if (auto_mem && bus.imem_req) begin
        pend  = 1;
        cnt   = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
        paddr = bus.imem_addr;
      end
    end
  end

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (is_hlt(w)) w[7:4] = 4'h0;
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; exec = 1'b0; redirect_valid = 1'b0; bus.instr_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_exec();
    @(negedge clock); exec = 1'b1;
    @(negedge clock); exec = 1'b0;
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic        ex;
    logic        rv;
    logic [15:0] rd;
    logic        rdy;
    logic        rdr;
    logic [15:0] rpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_val;
    logic [15:0] e_instr;
    logic [15:0] e_ipc;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          hs;
    int          reqs;
    logic [15:0] exp_pc, last_pc, prev_instr, prev_ipc;
    logic        prev_hold;
    bit          seen;

    bus.instr_ready   = 1'b0;
    bus2.instr_ready  = 1'b0;
    bus2.imem_rvalid  = 1'b0;
    bus2.imem_rdata   = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = rand_word();

    //              ex rv rd        rdy rdr rpc       req addr      val instr     ipc
    tbl[0]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000};
    tbl[1]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0000,1'b0,16'h0000,16'h0000};
    tbl[2]  = '{1'b0,1'b1,16'h8801,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000};
    for (int i = 3; i <= 7; i++)
      tbl[i] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h8801,16'h0000};
    tbl[8]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h8801,16'h0000};
    tbl[9]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0001,1'b0,16'h0000,16'h0000};
    tbl[10] = '{1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0040, 1'b0,16'h0000,1'b0,16'h0000,16'h0000};
    tbl[11] = '{1'b0,1'b1,16'h1234,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000};
    tbl[12] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0040,1'b0,16'h0000,16'h0000};
    tbl[13] = '{1'b0,1'b1,16'h0007,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000};
    tbl[14] = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h0007,16'h0040};
    tbl[15] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0041,1'b0,16'h0000,16'h0000};
    tbl[16] = '{1'b0,1'b1,16'h2222,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000};
    tbl[17] = '{1'b0,1'b0,16'h0000,1'b1,1'b1,16'h0080, 1'b0,16'h0000,1'b1,16'h2222,16'h0041};
    tbl[18] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0080,1'b0,16'h0000,16'h0000};
    tbl[19] = '{1'b0,1'b1,16'h3333,1'b0,1'b1,16'h00A0, 1'b0,16'h0000,1'b0,16'h0000,16'h0000};
    tbl[20] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h00A0,1'b0,16'h0000,16'h0000};
    tbl[21] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000};

    // ---- reset values ----
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_state", {bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc, halted},
        {1'b0, 16'h0000, 1'b0, INSTR_NOP, 16'h0000, 1'b0});
    chk("reset_pc_ffff", {bus2.imem_req, bus2.imem_addr, bus2.instr_valid, halted2},
        {1'b0, 16'hFFFF, 1'b0, 1'b0});

    // ---- RESET_PC = FFFF wraps to 0 ----
    @(negedge clock); exec2 = 1'b1;
    @(negedge clock); exec2 = 1'b0;
    chk("wrap_req", {bus2.imem_req, bus2.imem_addr}, {1'b1, 16'hFFFF});
    @(negedge clock); bus2.imem_rvalid = 1'b1; bus2.imem_rdata = 16'h0001;
    @(negedge clock); bus2.imem_rvalid = 1'b0;
    chk("wrap_instr", {bus2.instr_valid, bus2.instr_pc, bus2.instr}, {1'b1, 16'hFFFF, 16'h0001});
    bus2.instr_ready = 1'b1;
    @(negedge clock); bus2.instr_ready = 1'b0;
    chk("wrap_next_req", {bus2.imem_req, bus2.imem_addr}, {1'b1, 16'h0000});

    // ---- directed table (dut is in IDLE, out of reset) ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      chk($sformatf("vec%0d", i),
          {bus.imem_req, bus.imem_req ? bus.imem_addr : 16'h0, bus.instr_valid,
           bus.instr_valid ? bus.instr : 16'h0, bus.instr_valid ? bus.instr_pc : 16'h0, halted},
          {tbl[i].e_req, tbl[i].e_req ? tbl[i].e_addr : 16'h0, tbl[i].e_val,
           tbl[i].e_instr, tbl[i].e_ipc, 1'b0});
      exec             = tbl[i].ex;
      man_rvalid       = tbl[i].rv;
      man_rdata        = tbl[i].rd;
      bus.instr_ready  = tbl[i].rdy;
      redirect_valid   = tbl[i].rdr;
      redirect_pc      = tbl[i].rpc;
    end
    @(negedge clock);
    exec = 1'b0; man_rvalid = 1'b0; bus.instr_ready = 1'b0; redirect_valid = 1'b0;

    // ---- randomized run against the instruction-stream model ----
    // Model: the delivered stream is mem[] read sequentially from RESET_PC;
    // a redirect restarts the sequence at its target and squashes whatever
    // was held or in flight.
    do_reset();
    auto_mem = 1'b1; fixed_lat = 0;
    pulse_exec();
    exp_pc = 16'h0000; hs = 0; prev_hold = 1'b0; prev_instr = 0; prev_ipc = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (prev_hold && bus.instr_valid)
        chk("rand_stable", {bus.instr, bus.instr_pc}, {prev_instr, prev_ipc});
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 24) == 0);
      redirect_pc     = 16'($urandom_range(0, 255));
      if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (bus.instr_valid && bus.instr_ready) begin
        chk("rand_pc", bus.instr_pc, exp_pc);
        chk("rand_instr", bus.instr, mem[exp_pc[7:0]]);
        exp_pc = exp_pc + 16'd1;
        hs++;
      end
      prev_hold  = bus.instr_valid && !bus.instr_ready && !redirect_valid;
      prev_instr = bus.instr;
      prev_ipc   = bus.instr_pc;
    end
    @(negedge clock); bus.instr_ready = 1'b0; redirect_valid = 1'b0;
    chk("rand_progress", (hs >= 100), 1'b1);
`ifdef SIMPLE_FETCH_STATS_EN
    @(negedge clock);
    chk("stats_fetch_count", fetch_count, 32'(hs));
`endif

    // ---- HLT at address 5, then resume ----
    do_reset();
    for (int i = 0; i < 5; i++) mem[i] = rand_word();
    mem[5] = INSTR_HLT;
    fixed_lat = 1;
    bus.instr_ready = 1'b1;
    pulse_exec();
    hs = 0; last_pc = 16'hDEAD; seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clock);
      if (bus.instr_valid) begin
        last_pc = bus.instr_pc;
        hs++;
      end
      seen = halted;
    end
    chk("hlt_halted", halted, 1'b1);
    chk("hlt_last_pc", last_pc, 16'h0005);
    chk("hlt_count", hs, 6);
    reqs = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (bus.imem_req || !halted) reqs++;
    end
    chk("hlt_quiet", reqs, 0);
    pulse_exec();
    chk("resume_req", {bus.imem_req, bus.imem_addr, halted}, {1'b1, 16'h0006, 1'b0});

    // ---- reset during WAIT, late rvalid ignored ----
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = rand_word();
    fixed_lat = 2;
    bus.instr_ready = 1'b1;
    pulse_exec();
    hs = 0; seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clock);
      if (bus.instr_valid) hs++;
      seen = (hs >= 2) && bus.imem_req;
    end
    chk("rst_mid_reached", {seen, bus.imem_addr}, {1'b1, 16'h0002});
    @(negedge clock); reset = 1'b1;    // now in WAIT
    @(negedge clock); reset = 1'b0;    // stale rvalid presented this cycle
    reqs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (bus.instr_valid || bus.imem_req || halted || (bus.imem_addr != 16'h0000)) reqs++;
    end
    chk("rst_mid_idle", reqs, 0);
    pulse_exec();
    chk("rst_mid_restart", {bus.imem_req, bus.imem_addr}, {1'b1, 16'h0000});

    auto_mem = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
